load_store_unit: RTL and testbench

- CPU-side initiator for the byte-addressable data memory.
- Accepts one load/store request at a time from the execute stage through a valid/ready handshake.
- Drives the memory's read/write/funct3/addr/write_val port and returns load data with a single-cycle response pulse.
- The memory forms halfword/word byte addresses as {addr[8:2], lane}, so it cannot serve misaligned accesses. This block therefore splits any misaligned LH/LHU/LW/SH/SW into sequential byte accesses and range-checks every address.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_extend.sv | 34 +++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its helpers.
package lsu_pkg;

  localparam int DEF_MEM_ADDR_W = 9;
  localparam int DEF_MEM_BYTES  = 512;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

  typedef struct packed {
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                        (f3 == F3_BU) || (f3 == F3_HU);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Access size decode, alignment test and load-value extension; purely combinational,
// no latency, no flow control.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw,
  output logic [2:0]  size,
  output logic        aligned,
  output logic [31:0] ext_val
);

  always_comb begin
    size    = 3'd4;
    aligned = (addr_lo == 2'b00);
    case (funct3[1:0])
      2'b00: begin size = 3'd1; aligned = 1'b1;        end
      2'b01: begin size = 3'd2; aligned = ~addr_lo[0]; end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B:    ext_val = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   ext_val = {24'b0, raw[7:0]};
      F3_H:    ext_val = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   ext_val = {16'b0, raw[15:0]};
      default: ext_val = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request in flight, misaligned accesses split into bytes.
// Latency accept->resp: fault 1, aligned 2, split half 3, split word 5; req_ready low while busy.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int MEM_BYTES  = DEF_MEM_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_load,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [2:0]            mem_funct3,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  state_t                state;
  lsu_req_t              cap;
  logic [MEM_ADDR_W-1:0] cap_addr;
  logic [1:0]            idx;
  logic [31:0]           asm_q;

  logic [2:0]  ext_f3;
  logic [1:0]  ext_lo;
  logic [2:0]  size;
  logic        aligned;
  logic [31:0] asm_next;
  logic [31:0] ext_val;
  logic [31:0] wdata_sh;
  logic [1:0]  last_idx;
  logic [32:0] end_addr;
  logic        fault;

  // The extender serves the fault/alignment check in IDLE and the split assembly afterwards.
  assign ext_f3 = (state == IDLE) ? req_funct3     : cap.funct3;
  assign ext_lo = (state == IDLE) ? req_addr[1:0]  : cap_addr[1:0];

  lsu_extend u_ext (
    .funct3  (ext_f3),
    .addr_lo (ext_lo),
    .raw     (asm_next),
    .size    (size),
    .aligned (aligned),
    .ext_val (ext_val)
  );

  assign asm_next = asm_q | ({24'b0, mem_rdata[7:0]} << {idx, 3'b000});
  assign wdata_sh = cap.wdata >> {idx, 3'b000};
  assign last_idx = 2'(size - 3'd1);
  assign end_addr = {1'b0, req_addr} + {30'b0, size} - 33'd1;

  assign fault = (req_load == req_store) ||
                 !f3_legal(req_load, req_funct3) ||
                 (|req_addr[31:MEM_ADDR_W]) ||
                 (end_addr > 33'(MEM_BYTES - 1));

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'b000;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ACCESS: begin
        mem_read   = cap.load;
        mem_write  = cap.store;
        mem_funct3 = cap.funct3;
        mem_addr   = cap_addr;
        mem_wdata  = cap.wdata;
      end
      SPLIT: begin
        mem_read   = cap.load;
        mem_write  = cap.store;
        mem_funct3 = cap.load ? F3_BU : F3_B;
        mem_addr   = cap_addr + MEM_ADDR_W'(idx);
        mem_wdata  = {24'b0, wdata_sh[7:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      cap        <= '0;
      cap_addr   <= '0;
      idx        <= '0;
      asm_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cap       <= '{load: req_load, store: req_store, funct3: req_funct3, wdata: req_wdata};
            cap_addr  <= req_addr[MEM_ADDR_W-1:0];
            idx       <= '0;
            asm_q     <= '0;
            req_ready <= 1'b0;
            if (fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= aligned ? ACCESS : SPLIT;
            end
          end
        end
        ACCESS: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_fault <= 1'b0;
          resp_rdata <= cap.load ? mem_rdata : '0;
        end
        SPLIT: begin
          asm_q <= asm_next;
          idx   <= idx + 2'd1;
          if (idx == last_idx) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_rdata <= cap.load ? ext_val : '0;
          end
        end
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random requests against a byte-array model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem    [512] = '{default: 8'h00};
  logic [7:0] refmem [512] = '{default: 8'h00};
  logic [2:0] ld_f3s [5]   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: halfword/word lanes are formed from the aligned base address.
  always_comb begin
    mem_rdata = '0;
    case (mem_funct3)
      3'b000: mem_rdata = {{24{mem[mem_addr][7]}}, mem[mem_addr]};
      3'b100: mem_rdata = {24'b0, mem[mem_addr]};
      3'b001: mem_rdata = {{16{mem[{mem_addr[8:1], 1'b1}][7]}},
                           mem[{mem_addr[8:1], 1'b1}], mem[{mem_addr[8:1], 1'b0}]};
      3'b101: mem_rdata = {16'b0, mem[{mem_addr[8:1], 1'b1}], mem[{mem_addr[8:1], 1'b0}]};
      3'b010: mem_rdata = {mem[{mem_addr[8:2], 2'b11}], mem[{mem_addr[8:2], 2'b10}],
                           mem[{mem_addr[8:2], 2'b01}], mem[{mem_addr[8:2], 2'b00}]};
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_funct3)
        3'b000: mem[mem_addr] <= mem_wdata[7:0];
        3'b001: begin
          mem[{mem_addr[8:1], 1'b0}] <= mem_wdata[7:0];
          mem[{mem_addr[8:1], 1'b1}] <= mem_wdata[15:8];
        end
        3'b010: begin
          mem[{mem_addr[8:2], 2'b00}] <= mem_wdata[7:0];
          mem[{mem_addr[8:2], 2'b01}] <= mem_wdata[15:8];
          mem[{mem_addr[8:2], 2'b10}] <= mem_wdata[23:16];
          mem[{mem_addr[8:2], 2'b11}] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request through the handshake, judged against the byte-array model.
  task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] got);
    int          e_size, e_lat, e_n, lat, nobs;
    logic        e_fault, e_aligned, rdy_seen;
    logic [31:0] raw, e_rdata;
    logic [45:0] obs [8];
    logic [45:0] ex;

    e_size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    e_fault   = (ld == st) ||
                (ld && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                (st && !(f3 inside {3'b000, 3'b001, 3'b010})) ||
                (addr > 32'd511) || (longint'(addr) + e_size - 1 > 511);
    e_aligned = (addr % e_size) == 0;
    e_lat     = e_fault ? 1 : e_aligned ? 2 : e_size + 1;
    e_n       = e_fault ? 0 : e_aligned ? 1 : e_size;
    raw = '0;
    if (!e_fault)
      for (int i = 0; i < e_size; i++) raw = raw | (32'(refmem[int'(addr) + i]) << (8 * i));
    case (f3)
      3'b000:  e_rdata = {{24{raw[7]}}, raw[7:0]};
      3'b001:  e_rdata = {{16{raw[15]}}, raw[15:0]};
      3'b100:  e_rdata = raw & 32'hFF;
      3'b101:  e_rdata = raw & 32'hFFFF;
      default: e_rdata = raw;
    endcase
    if (e_fault || !ld) e_rdata = '0;

    rdy_seen = 1'b0;
    for (int k = 0; k < 20 && !rdy_seen; k++) begin
      @(negedge clk);
      rdy_seen = req_ready;
    end
    check_eq("ready", 64'(rdy_seen), 64'd1);
    req_valid = 1'b1; req_load = ld; req_store = st;
    req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0; nobs = 0; got = '0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if ((mem_read || mem_write) && nobs < 8) begin
        obs[nobs] = {mem_read, mem_write, mem_addr, mem_funct3, ld ? 32'h0 : mem_wdata};
        nobs++;
      end
      if (resp_valid) begin
        lat = c;
        got = resp_rdata;
        check_eq("fault", 64'(resp_fault), 64'(e_fault));
        check_eq("rdata", 64'(resp_rdata), 64'(e_rdata));
      end
    end
    check_eq("latency", 64'(lat), 64'(e_lat));
    check_eq("n_access", 64'(nobs), 64'(e_n));
    for (int i = 0; i < e_n && i < nobs; i++) begin
      if (e_aligned)
        ex = {ld, st, addr[8:0], f3, ld ? 32'h0 : wd};
      else
        ex = {ld, st, 9'(addr[8:0] + 9'(i)), ld ? 3'b100 : 3'b000,
              ld ? 32'h0 : ((wd >> (8 * i)) & 32'hFF)};
      check_eq("trace", 64'(obs[i]), 64'(ex));
    end
    if (st && !e_fault)
      for (int i = 0; i < e_size; i++) refmem[int'(addr) + i] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  initial begin
    logic [31:0] got;
    logic [7:0]  sb_bytes [4];
    logic        lf, sf;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r, nbad;

    sb_bytes = '{8'h44, 8'h33, 8'h22, 8'h11};
    repeat (2) @(negedge clk);
    check_eq("reset_ctl", {60'b0, req_ready, resp_valid, resp_fault, mem_read | mem_write},
             {60'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    check_eq("reset_dat", {resp_rdata, mem_wdata}, 64'h0);
    check_eq("reset_mem", {mem_funct3, mem_addr}, 64'h0);
    rst = 1'b0;

    do_req(0, 1, 3'b010, 32'h010, 32'hDEADBEEF, got);
    do_req(1, 0, 3'b010, 32'h010, 32'h0, got);
    check_eq("lw_const", 64'(got), 64'hDEADBEEF);

    do_req(0, 1, 3'b000, 32'h021, 32'h34, got);
    do_req(0, 1, 3'b000, 32'h022, 32'h82, got);
    do_req(1, 0, 3'b001, 32'h021, 32'h0, got);
    check_eq("lh_const", 64'(got), 64'hFFFF8234);
    do_req(1, 0, 3'b101, 32'h021, 32'h0, got);
    check_eq("lhu_const", 64'(got), 64'h00008234);

    do_req(1, 0, 3'b010, 32'h1FE, 32'h0, got);
    do_req(1, 0, 3'b011, 32'h020, 32'h0, got);
    do_req(0, 1, 3'b100, 32'h020, 32'h5, got);
    do_req(1, 0, 3'b000, 32'h200, 32'h0, got);
    do_req(1, 1, 3'b000, 32'h020, 32'h0, got);

    // Split SW at 0x003 with req_valid held; the follow-on LW must wait until after RESP.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
    req_funct3 = 3'b010; req_addr = 32'h003; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_load = 1'b1; req_store = 1'b0; req_addr = 32'h004; req_wdata = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check_eq("hold_rdy", 64'(req_ready), 64'd0);
      if (c <= 4)
        check_eq("hold_sb", {mem_read, mem_write, mem_funct3, mem_addr, mem_wdata},
                 {1'b0, 1'b1, 3'b000, 9'(2 + c), 24'b0, sb_bytes[c-1]});
      else
        check_eq("hold_resp", 64'(resp_valid), 64'd1);
    end
    for (int i = 0; i < 4; i++) refmem[3 + i] = sb_bytes[i];
    @(negedge clk);
    check_eq("hold_idle", {62'b0, req_ready, mem_read}, {62'b0, 1'b1, 1'b0});
    @(negedge clk);
    check_eq("hold_acc", {mem_read, mem_addr}, {1'b1, 9'h004});
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("hold_lw", {resp_valid, resp_rdata}, {1'b1, 32'h00112233});

    // Reset while the third byte of a split SW at 0x041 is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1;
    req_funct3 = 3'b010; req_addr = 32'h041; req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_wr", {mem_write, mem_addr}, {1'b1, 9'h043});
    #1 rst = 1'b1;
    #1;
    check_eq("rst_async_ctl", {mem_read, mem_write, resp_valid, resp_fault, mem_funct3, mem_addr},
             64'h0);
    check_eq("rst_async_dat", {resp_rdata, mem_wdata}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 64'(req_ready), 64'd1);
    check_eq("rst_bytes", {mem[9'h041], mem[9'h042], mem[9'h043], mem[9'h044]},
             {8'hD4, 8'hC3, refmem[9'h043], refmem[9'h044]});
    refmem[9'h041] = 8'hD4;
    refmem[9'h042] = 8'hC3;

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      begin lf = 1'b1; sf = 1'b1; end
      else if (r == 1) begin lf = 1'b0; sf = 1'b0; end
      else begin lf = 1'($urandom_range(0, 1)); sf = !lf; end
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (lf)                   f3 = ld_f3s[$urandom_range(0, 4)];
      else                           f3 = 3'($urandom_range(0, 2));
      r = $urandom_range(0, 15);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h1F8 + 32'($urandom_range(0, 7));
      else             a = 32'($urandom_range(0, 127));
      do_req(lf, sf, f3, a, $urandom, got);
    end

    nbad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== refmem[i]) nbad++;
    check_eq("mem_image", 64'(nbad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
